// File: rtl/screen_scanout.sv
// Raster scan-out engine for the monochrome frame buffer: fetches each 16-pixel
// word two clocks ahead of the beam and serialises it with sync and frame markers.
module screen_scanout #(
    parameter int H_ACTIVE     = 512,
    parameter int H_TOTAL      = 640,
    parameter int H_SYNC_START = 528,
    parameter int H_SYNC_LEN   = 64,
    parameter int V_ACTIVE     = 256,
    parameter int V_TOTAL      = 280,
    parameter int V_SYNC_START = 260,
    parameter int V_SYNC_LEN   = 4,
    parameter int ADR_W        = 13
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             scan_en,
    output logic             rd_en,
    output logic [ADR_W-1:0] rd_adr,
    input  logic [15:0]      rd_data,
    output logic             pixel,
    output logic             pixel_valid,
    output logic             hsync,
    output logic             vsync,
    output logic             frame_start,
    output logic [15:0]      frame_cnt,
    output logic             busy
);
    localparam int WORDS = H_ACTIVE / 16;
    localparam int H_W   = $clog2(H_TOTAL);
    localparam int V_W   = $clog2(V_TOTAL);

    localparam logic [H_W-1:0] H_LAST      = H_W'(H_TOTAL - 1);
    localparam logic [H_W-1:0] H_PREFETCH  = H_W'(H_TOTAL - 2);
    localparam logic [H_W-1:0] H_ACT       = H_W'(H_ACTIVE);
    localparam logic [H_W-1:0] H_MID_LIMIT = H_W'(H_ACTIVE - 2);
    localparam logic [H_W-1:0] HS_FIRST    = H_W'(H_SYNC_START);
    localparam logic [H_W-1:0] HS_LAST     = H_W'(H_SYNC_START + H_SYNC_LEN - 1);
    localparam logic [V_W-1:0] V_LAST      = V_W'(V_TOTAL - 1);
    localparam logic [V_W-1:0] V_ACT       = V_W'(V_ACTIVE);
    localparam logic [V_W-1:0] VS_FIRST    = V_W'(V_SYNC_START);
    localparam logic [V_W-1:0] VS_LAST     = V_W'(V_SYNC_START + V_SYNC_LEN - 1);

    typedef enum logic {IDLE, RUN} state_t;

    state_t         state, state_next;
    logic [H_W-1:0] h, h_next;
    logic [V_W-1:0] v, v_next, v_inc;
    logic [15:0]    shift_reg;
    logic           load_slot, load_rd;

    logic           running, line_end_fetch, mid_fetch, fetch_slot;
    logic [V_W-1:0] fetch_line;
    logic [H_W-5:0] word_mid, fetch_word;

    assign running = (state == RUN);
    assign v_inc   = (v == V_LAST) ? '0 : v + V_W'(1);

    // Word k is requested at h=16k-2; word 0 is prefetched at the end of the previous line.
    assign line_end_fetch = (h == H_PREFETCH);
    assign mid_fetch      = (h[3:0] == 4'd14) && (h < H_MID_LIMIT);
    assign fetch_slot     = running && (line_end_fetch || mid_fetch);
    assign fetch_line     = line_end_fetch ? v_inc : v;
    assign word_mid       = h[H_W-1:4] + (H_W-4)'(1);
    assign fetch_word     = line_end_fetch ? '0 : word_mid;

    assign rd_en  = fetch_slot && (fetch_line < V_ACT);
    assign rd_adr = rd_en ? ADR_W'(fetch_line) * ADR_W'(WORDS) + ADR_W'(fetch_word) : '0;

    assign busy        = running;
    assign pixel_valid = running && (h < H_ACT) && (v < V_ACT);
    assign pixel       = pixel_valid && shift_reg[0];
    assign hsync       = running && (h >= HS_FIRST) && (h <= HS_LAST);
    assign vsync       = running && (v >= VS_FIRST) && (v <= VS_LAST);
    assign frame_start = running && (h == '0) && (v == '0);

    always_comb begin
        // NOTE: every signal gets a default first, so no path can infer a latch.
        state_next = state;
        h_next     = h;
        v_next     = v;
        unique case (state)
            IDLE: begin
                if (scan_en) begin
                    state_next = RUN;
                    h_next     = H_PREFETCH;
                    v_next     = V_LAST;
                end
            end
            RUN: begin
                if (h == H_LAST) begin
                    h_next = '0;
                    v_next = v_inc;
                    // scan_en only matters here, so a started frame always completes.
                    if (v == V_LAST && !scan_en) state_next = IDLE;
                end else begin
                    h_next = h + H_W'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (!reset) begin
            state     <= IDLE;
            h         <= '0;
            v         <= '0;
            shift_reg <= '0;
            frame_cnt <= '0;
            load_slot <= 1'b0;
            load_rd   <= 1'b0;
        end else begin
            state     <= state_next;
            h         <= h_next;
            v         <= v_next;
            load_slot <= fetch_slot;
            load_rd   <= rd_en;
            if (load_slot)
                shift_reg <= load_rd ? rd_data : 16'h0000;
            else
                shift_reg <= shift_reg >> 1;
            if (frame_start)
                frame_cnt <= frame_cnt + 16'd1;
        end
    end
endmodule

// File: tb/tb_screen_scanout.sv
// Directed bench: a shrunk raster instance checked cycle by cycle against a
// position model, plus a full-size instance spot-checked over its first lines.
module tb_screen_scanout;
    localparam int HA = 64, HT = 96, HSS = 72, HSL = 8;
    localparam int VA = 16, VT = 24, VSS = 18, VSL = 2, AW = 6;
    localparam int WS = HA / 16;
    localparam int FRAME = HT * VT;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset, scan_en, scan_en_f;

    logic          rd_en, pixel, pixel_valid, hsync, vsync, frame_start, busy;
    logic [AW-1:0] rd_adr;
    logic [15:0]   rd_data, frame_cnt;

    logic          f_rd_en, f_pixel, f_pixel_valid, f_hsync, f_vsync, f_frame_start, f_busy;
    logic [12:0]   f_rd_adr;
    logic [15:0]   f_rd_data, f_frame_cnt;

    logic [15:0] mem_s [0:63];
    logic [15:0] mem_f [0:8191];

    screen_scanout #(
        .H_ACTIVE(HA), .H_TOTAL(HT), .H_SYNC_START(HSS), .H_SYNC_LEN(HSL),
        .V_ACTIVE(VA), .V_TOTAL(VT), .V_SYNC_START(VSS), .V_SYNC_LEN(VSL), .ADR_W(AW)
    ) dut (
        .clk(clk), .reset(reset), .scan_en(scan_en),
        .rd_en(rd_en), .rd_adr(rd_adr), .rd_data(rd_data),
        .pixel(pixel), .pixel_valid(pixel_valid), .hsync(hsync), .vsync(vsync),
        .frame_start(frame_start), .frame_cnt(frame_cnt), .busy(busy)
    );

    screen_scanout dut_full (
        .clk(clk), .reset(reset), .scan_en(scan_en_f),
        .rd_en(f_rd_en), .rd_adr(f_rd_adr), .rd_data(f_rd_data),
        .pixel(f_pixel), .pixel_valid(f_pixel_valid), .hsync(f_hsync), .vsync(f_vsync),
        .frame_start(f_frame_start), .frame_cnt(f_frame_cnt), .busy(f_busy)
    );

    // Read ports with one cycle of latency; junk is returned when no read was issued.
    always @(posedge clk) begin
        rd_data   <= rd_en   ? mem_s[rd_adr]   : 16'hdead;
        f_rd_data <= f_rd_en ? mem_f[f_rd_adr] : 16'hdead;
    end

    int n_checks = 0, n_errors = 0;
    int cyc_err = 0;
    int tot_hs, tot_vs, tot_pv, tot_rd, tot_px, tot_fs;
    int f_cyc = -1;

    bit          m_run = 1'b0;
    int          eh = 0, ev = 0;
    logic [15:0] m_cnt = 16'h0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_totals();
        tot_hs = 0; tot_vs = 0; tot_pv = 0; tot_rd = 0; tot_px = 0; tot_fs = 0;
    endtask

    task automatic full_checks();
        case (f_cyc)
            0: begin
                check("f_first_rd_en", f_rd_en, 1);
                check("f_first_rd_adr", f_rd_adr, 0);
                check("f_first_busy", f_busy, 1);
                check("f_first_fs", f_frame_start, 0);
            end
            1:   check("f_h639_rd_en", f_rd_en, 0);
            2: begin
                check("f_frame_start", f_frame_start, 1);
                check("f_px_h0_v0", f_pixel, 1);
            end
            3: begin
                check("f_frame_cnt", f_frame_cnt, 1);
                check("f_px_h1_v0", f_pixel, 0);
            end
            16: begin
                check("f_rd_en_h14", f_rd_en, 1);
                check("f_rd_adr_h14", f_rd_adr, 1);
            end
            17:  check("f_px_h15_v0", f_pixel, 0);
            513: check("f_pv_h511", f_pixel_valid, 1);
            514: check("f_pv_h512", f_pixel_valid, 0);
            529: check("f_hs_h527", f_hsync, 0);
            530: check("f_hs_h528", f_hsync, 1);
            593: check("f_hs_h591", f_hsync, 1);
            594: check("f_hs_h592", f_hsync, 0);
            640: check("f_rd_adr_line1_w0", f_rd_adr, 32);
            656: check("f_rd_adr_line1_w1", f_rd_adr, 33);
            672: check("f_px_h30_v1", f_pixel, 0);
            673: begin
                check("f_px_h31_v1", f_pixel, 1);
                check("f_vs_v1", f_vsync, 0);
            end
            674: check("f_px_h32_v1", f_pixel, 0);
            default: ;
        endcase
    endtask

    // Compare the current cycle, then apply inputs for the next edge and advance the model.
    task automatic step(input logic nrst, input logic en);
        logic [15:0] w;
        int          tl, e_adr;
        bit          slot, e_pv, e_px, e_hs, e_vs, e_fs, e_rd;
        @(negedge clk);
        e_pv  = m_run && eh < HA && ev < VA;
        w     = e_pv ? mem_s[ev*WS + eh/16] : 16'h0;
        e_px  = e_pv && w[eh%16];
        e_hs  = m_run && eh >= HSS && eh < HSS + HSL;
        e_vs  = m_run && ev >= VSS && ev < VSS + VSL;
        e_fs  = m_run && eh == 0 && ev == 0;
        tl    = (eh == HT-2) ? (ev + 1) % VT : ev;
        slot  = m_run && (eh == HT-2 || (eh % 16 == 14 && eh < HA-2));
        e_rd  = slot && tl < VA;
        e_adr = e_rd ? tl*WS + ((eh == HT-2) ? 0 : (eh + 2) / 16) : 0;
        if ({busy, rd_en, rd_adr, pixel, pixel_valid, hsync, vsync, frame_start, frame_cnt} !==
            {m_run, e_rd, AW'(e_adr), e_px, e_pv, e_hs, e_vs, e_fs, m_cnt})
            cyc_err++;
        tot_hs += int'(hsync);  tot_vs += int'(vsync);  tot_pv += int'(pixel_valid);
        tot_rd += int'(rd_en);  tot_px += int'(pixel);  tot_fs += int'(frame_start);

        if (m_run && eh == HT-2 && ev == VT-1) begin
            check("prefetch_rd_en", rd_en, 1);
            check("prefetch_adr0", rd_adr, 0);
        end
        if (m_run && ev == 0  && eh == 0)  check("px_h0_v0", pixel, 1);
        if (m_run && ev == 0  && eh == 1)  check("px_h1_v0", pixel, 0);
        if (m_run && ev == 0  && eh == 15) check("px_h15_v0", pixel, 0);
        if (m_run && ev == 1  && eh == 30) check("px_h30_v1", pixel, 0);
        if (m_run && ev == 1  && eh == 31) check("px_h31_v1", pixel, 1);
        if (m_run && ev == 2  && eh == 32) check("px_a5a5_b0", pixel, 1);
        if (m_run && ev == 2  && eh == 33) check("px_a5a5_b1", pixel, 0);
        if (m_run && ev == 15 && eh == 63) check("px_h63_v15", pixel, 1);
        if (m_run && ev == 15 && eh == 64) check("pv_h64_v15", pixel_valid, 0);
        if (m_run && ev == 3  && eh == 71) check("hs_h71", hsync, 0);
        if (m_run && ev == 3  && eh == 72) check("hs_h72", hsync, 1);
        if (m_run && ev == 3  && eh == 80) check("hs_h80", hsync, 0);
        if (m_run && ev == 17 && eh == 0)  check("vs_v17", vsync, 0);
        if (m_run && ev == 18 && eh == 0)  check("vs_v18", vsync, 1);
        if (m_run && ev == 20 && eh == 0)  check("vs_v20", vsync, 0);

        if (f_cyc >= 0 && f_cyc < 1000) begin
            full_checks();
            f_cyc++;
        end

        reset   = nrst;
        scan_en = en;

        if (!nrst) begin
            m_run = 1'b0; eh = 0; ev = 0; m_cnt = 16'h0;
        end else if (!m_run) begin
            if (en) begin
                m_run = 1'b1; eh = HT - 2; ev = VT - 1;
            end
        end else begin
            if (e_fs) m_cnt = m_cnt + 16'd1;
            if (eh == HT - 1) begin
                eh = 0;
                if (ev == VT - 1) begin
                    ev = 0;
                    if (!en) m_run = 1'b0;
                end else begin
                    ev++;
                end
            end else begin
                eh++;
            end
        end
    endtask

    task automatic check_frame_totals(input string phase, input int exp_rd, input int exp_cnt);
        check({phase, "_cycle_diffs"}, cyc_err, 0);
        check({phase, "_hsync_total"}, tot_hs, 8 * 24);
        check({phase, "_vsync_total"}, tot_vs, 2 * 96);
        check({phase, "_valid_total"}, tot_pv, 64 * 16);
        check({phase, "_rd_total"}, tot_rd, exp_rd);
        check({phase, "_fs_total"}, tot_fs, 1);
        check({phase, "_frame_cnt"}, frame_cnt, exp_cnt);
    endtask

    initial begin
        reset = 1'b0; scan_en = 1'b1; scan_en_f = 1'b1;
        for (int i = 0; i < 64; i++)   mem_s[i] = 16'h0000;
        for (int i = 0; i < 8192; i++) mem_f[i] = 16'h0000;
        mem_s[0]  = 16'h0001;  mem_s[5]  = 16'h8000;
        mem_s[10] = 16'ha5a5;  mem_s[63] = 16'h8000;
        mem_f[0]  = 16'h0001;  mem_f[33] = 16'h8000;  mem_f[8191] = 16'h8000;

        // Reset held for three edges with scan_en already requested.
        step(0, 1); step(0, 1); step(1, 1);
        check("rst_outputs", {busy, rd_en, pixel, pixel_valid, hsync, vsync, frame_start}, 0);
        check("rst_rd_adr", rd_adr, 0);
        check("rst_frame_cnt", frame_cnt, 0);
        check("rst_full_outputs", {f_busy, f_rd_en, f_pixel, f_pixel_valid, f_hsync, f_vsync, f_frame_start}, 0);
        check("rst_full_frame_cnt", f_frame_cnt, 0);

        // Frame 1, scan_en held.
        f_cyc = 0;
        clear_totals();
        repeat (FRAME) step(1, 1);
        check_frame_totals("frame1", 64, 1);
        check("frame1_px_total", tot_px, 11);

        // Frame 2, scan_en dropped at line 5; the frame must still complete.
        clear_totals();
        for (int i = 0; i < FRAME; i++) step(1, i < 2 + 5 * HT);
        check_frame_totals("frame2", 64, 2);
        step(1, 0);
        check("spurious_rd_en", rd_en, 1);
        check("spurious_rd_adr", rd_adr, 0);
        step(1, 0);
        check("last_cycle_busy", busy, 1);
        step(1, 0);
        check("idle_busy", busy, 0);
        clear_totals();
        repeat (300) step(1, 0);
        check("idle_rd_total", tot_rd, 0);
        check("idle_fs_total", tot_fs, 0);
        check("idle_frame_cnt", frame_cnt, 2);
        check("idle_cycle_diffs", cyc_err, 0);

        // Restart, then reset mid-line at h=40, v=5.
        step(1, 1);
        for (int i = 0; i <= 2 + 5 * HT + 40; i++) step(i != 2 + 5 * HT + 40, 1);
        step(1, 1);
        check("midrst_outputs", {busy, rd_en, pixel, pixel_valid, hsync, vsync, frame_start}, 0);
        check("midrst_frame_cnt", frame_cnt, 0);
        clear_totals();
        step(1, 1);
        check("restart_rd_en", rd_en, 1);
        check("restart_rd_adr", rd_adr, 0);
        repeat (FRAME - 1) step(1, 1);
        check_frame_totals("restart", 64, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
